ifft_16pt: RTL and testbench



---
 rtl/ifft_16pt.sv | 160 ++++++++++++++++
 tb/tb_ifft_16pt.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_16pt.sv
// 16-point radix-2 DIT inverse FFT: one butterfly stage per clock, 1/16 scaling
// spread as a halving in every stage, saturating Q1.17 arithmetic.

module ifft_16pt_bfly (
  input  logic [35:0] a,
  input  logic [35:0] b,
  input  logic [2:0]  k,
  output logic [35:0] p,
  output logic [35:0] q
);
  logic signed [17:0] ar, ai, br, bi, cr, ci;
  logic signed [35:0] rr, ii, ri, ir;
  logic signed [36:0] mr, mi;
  logic signed [18:0] wr, wi;
  logic signed [19:0] sp_r, sp_i, sq_r, sq_i;

  function automatic logic [17:0] sat(input logic signed [19:0] s);
    logic signed [19:0] h;
    h = s >>> 1;
    if (h > 20'sd131071)       return 18'h1FFFF;
    else if (h < -20'sd131072) return 18'h20000;
    else                       return h[17:0];
  endfunction

  // Conjugate twiddles W^-k = cos + j*sin in Q1.17
  always_comb begin
    unique case (k)
      3'd0:    begin cr =  18'sd131071; ci =  18'sd0;      end
      3'd1:    begin cr =  18'sd121095; ci =  18'sd50159;  end
      3'd2:    begin cr =  18'sd92682;  ci =  18'sd92682;  end
      3'd3:    begin cr =  18'sd50159;  ci =  18'sd121095; end
      3'd4:    begin cr =  18'sd0;      ci =  18'sd131071; end
      3'd5:    begin cr = -18'sd50159;  ci =  18'sd121095; end
      3'd6:    begin cr = -18'sd92682;  ci =  18'sd92682;  end
      default: begin cr = -18'sd121095; ci =  18'sd50159;  end
    endcase
  end

  always_comb begin
    ar = a[35:18]; ai = a[17:0];
    br = b[35:18]; bi = b[17:0];
    rr = br * cr; ii = bi * ci;
    ri = br * ci; ir = bi * cr;
    mr = 37'(rr) - 37'(ii);
    mi = 37'(ri) + 37'(ir);
    // k0 and k4 are exact rotations; everything else truncates the product
    case (k)
      3'd0:    begin wr = {br[17], br};  wi = {bi[17], bi}; end
      3'd4:    begin wr = -{bi[17], bi}; wi = {br[17], br}; end
      default: begin wr = 19'(mr >>> 17); wi = 19'(mi >>> 17); end
    endcase
    sp_r = {ar[17], ar[17], ar} + {wr[18], wr};
    sp_i = {ai[17], ai[17], ai} + {wi[18], wi};
    sq_r = {ar[17], ar[17], ar} - {wr[18], wr};
    sq_i = {ai[17], ai[17], ai} - {wi[18], wi};
    p = {sat(sp_r), sat(sp_i)};
    q = {sat(sq_r), sat(sq_i)};
  end
endmodule

module ifft_16pt #(
  parameter int WIDTH = 36
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X [16],
  output logic [WIDTH-1:0] x [16],
  output logic             done
);
  typedef enum logic [2:0] {IDLE, STAGE1, STAGE2, STAGE3, STAGE4, DONE} state_t;
  state_t state, nxt;

  logic [35:0] w [16];
  logic [35:0] nw [16];
  logic [35:0] a_in [8], b_in [8], p_out [8], q_out [8];
  logic [3:0]  pidx [8], qidx [8];
  logic [2:0]  kidx [8];
  logic [3:0]  span;
  logic [1:0]  st;
  logic        accept, stage_en, last;

  function automatic logic [3:0] bitrev(input logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (start) nxt = STAGE1;
      STAGE1:     nxt = STAGE2;
      STAGE2:     nxt = STAGE3;
      STAGE3:     nxt = STAGE4;
      default:    nxt = DONE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE || state == DONE) && start;
    stage_en = 1'b1;
    last     = (state == STAGE4);
    unique case (state)
      STAGE1:  st = 2'd0;
      STAGE2:  st = 2'd1;
      STAGE3:  st = 2'd2;
      STAGE4:  st = 2'd3;
      default: begin st = 2'd0; stage_en = 1'b0; end
    endcase
  end

  // Butterfly b works on pair (p, p+span): p is b with a zero inserted at bit st
  always_comb begin
    span = 4'd1 << st;
    for (int b = 0; b < 8; b++) begin
      pidx[b] = 4'(((b >> st) << (st + 1)) | (b & ((1 << st) - 1)));
      qidx[b] = pidx[b] | span;
      kidx[b] = 3'((pidx[b] & (span - 4'd1)) << (2'd3 - st));
      a_in[b] = w[pidx[b]];
      b_in[b] = w[qidx[b]];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_bfly
    ifft_16pt_bfly u_bfly (
      .a(a_in[g]), .b(b_in[g]), .k(kidx[g]), .p(p_out[g]), .q(q_out[g])
    );
  end

  always_comb begin
    nw = w;
    for (int b = 0; b < 8; b++) begin
      nw[pidx[b]] = p_out[b];
      nw[qidx[b]] = q_out[b];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
    end else if (accept) begin
      done <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= X[bitrev(4'(i))];
    end else if (stage_en) begin
      w <= nw;
      if (last) begin
        x    <= nw;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ifft_16pt.sv
// Directed bench for ifft_16pt: reset, impulse/constant/single-bin transforms,
// control corner cases and saturation.

module tb_ifft_16pt;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [35:0] xin  [16];
  logic [35:0] xout [16];
  logic        done;
  int n_checks = 0;
  int n_fail   = 0;

  ifft_16pt #(.WIDTH(36)) dut (
    .clock(clock), .reset(reset), .start(start), .X(xin), .x(xout), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [35:0] cpx(input int re, input int im);
    logic [31:0] r, i;
    r = re; i = im;
    return {r[17:0], i[17:0]};
  endfunction

  function automatic int re_of(input logic [35:0] v);
    return int'($signed(v[35:18]));
  endfunction

  function automatic int im_of(input logic [35:0] v);
    return int'($signed(v[17:0]));
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic clear_bins();
    for (int k = 0; k < 16; k++) xin[k] = '0;
  endtask

  // Accepting edge N happens inside; returns just after it
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Edges N+1..N+4: done low for three, high on the fourth
  task automatic run_stages(input string tag);
    for (int e = 1; e <= 4; e++) begin
      step();
      n_checks++;
      if (done !== (e == 4)) begin
        n_fail++;
        $display("FAIL %s done after N+%0d: got %b want %b", tag, e, done, e == 4);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (xout[n] !== 36'd0) begin n_fail++; $display("FAIL reset x[%0d]: got %h want 0", n, xout[n]); end
    end
    for (int c = 0; c < 10; c++) step();
    n_checks++;
    if (done !== 1'b0 || xout[0] !== 36'd0) begin
      n_fail++; $display("FAIL idle hold: done %b x0 %h want 0 0", done, xout[0]);
    end
  endtask

  task automatic test_impulse();
    clear_bins();
    xin[0] = cpx(65536, 0);
    launch();
    run_stages("impulse");
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (xout[n] !== cpx(4096, 0)) begin
        n_fail++;
        $display("FAIL impulse x[%0d]: got (%0d,%0d) want (4096,0)", n, re_of(xout[n]), im_of(xout[n]));
      end
    end
  endtask

  task automatic test_constant();
    for (int k = 0; k < 16; k++) xin[k] = cpx(65536, 0);
    launch();
    run_stages("constant");
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (xout[n] !== ((n == 0) ? cpx(65536, 0) : 36'd0)) begin
        n_fail++;
        $display("FAIL constant x[%0d]: got (%0d,%0d) want (%0d,0)", n, re_of(xout[n]), im_of(xout[n]),
                 (n == 0) ? 65536 : 0);
      end
    end
  endtask

  task automatic test_single_bin();
    int idx [5] = '{0, 4, 8, 12, 2};
    int er  [5] = '{4096, 0, -4096, 0, 2896};
    int ei  [5] = '{0, 4096, 0, -4096, 2896};
    int dr, di;
    clear_bins();
    xin[1] = cpx(65536, 0);
    launch();
    run_stages("single_bin");
    for (int j = 0; j < 5; j++) begin
      dr = re_of(xout[idx[j]]) - er[j];
      di = im_of(xout[idx[j]]) - ei[j];
      n_checks++;
      if (dr > 2 || dr < -2 || di > 2 || di < -2) begin
        n_fail++;
        $display("FAIL single_bin x[%0d]: got (%0d,%0d) want (%0d,%0d) +-2", idx[j],
                 re_of(xout[idx[j]]), im_of(xout[idx[j]]), er[j], ei[j]);
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_bins();
    xin[0] = cpx(65536, 0);
    launch();
    step();                 // N+1: now in STAGE2
    start = 1'b1;
    xin[0] = cpx(-65536, 0);
    step();                 // N+2: start must be ignored
    start = 1'b0;
    step();                 // N+3
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL start_in_stage done N+3: got %b want 0", done); end
    step();                 // N+4
    n_checks++;
    if (done !== 1'b1 || xout[3] !== cpx(4096, 0)) begin
      n_fail++;
      $display("FAIL start_in_stage N+4: done %b x3 (%0d,%0d) want 1 (4096,0)", done,
               re_of(xout[3]), im_of(xout[3]));
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    clear_bins();
    xin[0] = cpx(65536, 0);
    launch();
    step(); step();         // now in STAGE3
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (done !== 1'b0 || xout[0] !== 36'd0 || xout[9] !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_abort: done %b x0 %h x9 %h want 0 0 0", done, xout[0], xout[9]);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_abort stale done: got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    clear_bins();
    xin[0] = cpx(65536, 0);
    launch();
    run_stages("b2b_first");
    for (int k = 0; k < 16; k++) xin[k] = cpx(65536, 0);
    start = 1'b1;
    step();                 // relaunch from DONE
    start = 1'b0;
    clear_bins();           // X may change after acceptance
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b done after relaunch: got %b want 0", done); end
    step(); step(); step(); // N+3
    n_checks++;
    if (done !== 1'b0 || xout[5] !== cpx(4096, 0)) begin
      n_fail++;
      $display("FAIL b2b N+3: done %b x5 (%0d,%0d) want 0 (4096,0)", done, re_of(xout[5]), im_of(xout[5]));
    end
    step();                 // N+4
    n_checks++;
    if (done !== 1'b1 || xout[0] !== cpx(65536, 0) || xout[5] !== 36'd0) begin
      n_fail++;
      $display("FAIL b2b N+4: done %b x0 (%0d,%0d) x5 (%0d,%0d) want 1 (65536,0) (0,0)", done,
               re_of(xout[0]), im_of(xout[0]), re_of(xout[5]), im_of(xout[5]));
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 16; k++) xin[k] = cpx(-131072, -131072);
    launch();
    run_stages("saturation");
    for (int n = 0; n < 16; n++) begin
      n_checks++;
      if (xout[n] !== ((n == 0) ? cpx(-131072, -131072) : 36'd0)) begin
        n_fail++;
        $display("FAIL saturation x[%0d]: got (%0d,%0d) want (%0d,%0d)", n, re_of(xout[n]), im_of(xout[n]),
                 (n == 0) ? -131072 : 0, (n == 0) ? -131072 : 0);
      end
    end
  endtask

  initial begin
    clear_bins();
    test_reset();
    test_impulse();
    test_constant();
    test_single_bin();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
